imem_loader: RTL and testbench

- Boot-time writer for the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word sequentially into the instruction RAM write port, starting at word address 0.
- Holds the CPU in reset until the image is fully written, then releases it. The CPU fetch path is the reader of the same memory.

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction RAM writer.
// Assembles a little-endian byte stream into 32-bit words, then releases the CPU.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           word_q, word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  xfer;
    logic [15:0]           hdr_len;

    assign xfer          = byte_valid && byte_ready;
    assign hdr_len       = {byte_data, len_q[7:0]};
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign words_written = cnt_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath updates and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        error      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    idx_d       = '0;
                    if (hdr_len == 16'd0)
                        state_d = S_DONE;
                    else if (32'(hdr_len) > DEPTH)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    word_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wdata_d = {byte_data, word_q[23:0]};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (32'(cnt_q) + 32'd1 == 32'(len_q))
                    state_d = S_DONE;
                else
                    state_d = S_DATA;
            end
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) begin
                    state_d = S_LEN_LO;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_ERR: begin
                error = 1'b1;
                if (start) begin
                    state_d = S_LEN_LO;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for two loader instances (8- and 4-bit address).
// A stream-level model predicts every output each cycle; literal checks pin it.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst, start, bv;
    logic [7:0] bd;

    logic        rdy [2];
    logic        we  [2];
    logic        cr  [2];
    logic        dn  [2];
    logic        er  [2];
    logic [31:0] wd  [2];
    logic [7:0]  addr0;
    logic [3:0]  addr1;
    logic [8:0]  ww0;
    logic [4:0]  ww1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(bv), .byte_data(bd), .byte_ready(rdy[0]),
        .mem_we(we[0]), .mem_addr(addr0), .mem_wdata(wd[0]),
        .cpu_rst(cr[0]), .done(dn[0]), .error(er[0]),
        .words_written(ww0)
    );

    imem_loader #(.ADDR_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(bv), .byte_data(bd), .byte_ready(rdy[1]),
        .mem_we(we[1]), .mem_addr(addr1), .mem_wdata(wd[1]),
        .cpu_rst(cr[1]), .done(dn[1]), .error(er[1]),
        .words_written(ww1)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // ---------------- stream-level model ----------------
    int          aw    [2] = '{8, 4};
    bit          m_load[2], m_done[2], m_err[2], m_wp[2];
    int          m_hb[2], m_n[2], m_db[2], m_wc[2];
    logic [31:0] m_word[2], m_lastw[2];

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_load[d] = 0; m_done[d] = 0; m_err[d] = 0; m_wp[d] = 0;
                m_hb[d] = 0; m_n[d] = 0; m_db[d] = 0; m_wc[d] = 0;
                m_word[d] = 0; m_lastw[d] = 0;
            end else if (m_wp[d]) begin
                m_wp[d] = 0;
                m_wc[d]++;
                if (m_wc[d] == m_n[d]) begin
                    m_load[d] = 0;
                    m_done[d] = 1;
                end
            end else if (m_load[d]) begin
                if (bv) begin
                    if (m_hb[d] < 2) begin
                        m_n[d] = m_n[d] + (int'(bd) << (8 * m_hb[d]));
                        m_hb[d]++;
                        if (m_hb[d] == 2) begin
                            if (m_n[d] == 0) begin
                                m_load[d] = 0; m_done[d] = 1;
                            end else if (m_n[d] > (1 << aw[d])) begin
                                m_load[d] = 0; m_err[d] = 1;
                            end
                        end
                    end else begin
                        m_word[d][8*m_db[d] +: 8] = bd;
                        m_db[d]++;
                        if (m_db[d] == 4) begin
                            m_wp[d] = 1;
                            m_lastw[d] = m_word[d];
                            m_db[d] = 0;
                        end
                    end
                end
            end else if (start) begin
                m_load[d] = 1; m_done[d] = 0; m_err[d] = 0;
                m_hb[d] = 0; m_n[d] = 0; m_db[d] = 0; m_wc[d] = 0;
            end
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    int          wl_a [2][$];
    logic [31:0] wl_d [2][$];
    logic [31:0] c_addr, c_ww;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            c_addr = (d == 0) ? 32'(addr0) : 32'(addr1);
            c_ww   = (d == 0) ? 32'(ww0)   : 32'(ww1);
            chk($sformatf("u%0d.byte_ready", d), 64'(rdy[d]), 64'(m_load[d] && !m_wp[d]));
            chk($sformatf("u%0d.mem_we", d), 64'(we[d]), 64'(m_wp[d]));
            chk($sformatf("u%0d.mem_addr", d), 64'(c_addr), 64'(m_wc[d] % (1 << aw[d])));
            chk($sformatf("u%0d.mem_wdata", d), 64'(wd[d]), 64'(m_lastw[d]));
            chk($sformatf("u%0d.cpu_rst", d), 64'(cr[d]), 64'(!m_done[d]));
            chk($sformatf("u%0d.done", d), 64'(dn[d]), 64'(m_done[d]));
            chk($sformatf("u%0d.error", d), 64'(er[d]), 64'(m_err[d]));
            chk($sformatf("u%0d.words_written", d), 64'(c_ww), 64'(m_wc[d]));
            if (we[d] === 1'b1) begin
                wl_a[d].push_back(int'(c_addr));
                wl_d[d].push_back(wd[d]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] sq[$];

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            wl_a[d].delete();
            wl_d[d].delete();
        end
    endtask

    task automatic add_hdr(input int n);
        sq.push_back(8'(n));
        sq.push_back(8'(n >> 8));
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) sq.push_back(w[8*k +: 8]);
    endtask

    task automatic basic_stream();
        sq.delete();
        add_hdr(2);
        add_word(32'h00100513);
        add_word(32'h00A505B3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        int n;
        repeat (gap) begin
            bv = 1'b0;
            @(posedge clk); #1;
        end
        bv = 1'b1;
        bd = b;
        n  = 0;
        forever begin
            @(negedge clk);
            r = rdy[0] || rdy[1];
            @(posedge clk); #1;
            if (r) break;
            n++;
            if (n > 40) begin
                tests++; fails++;
                $display("FAIL send_byte timeout: byte %0h not accepted in 40 cycles", b);
                break;
            end
        end
    endtask

    task automatic send_stream(input bit toggle, input int gap_at);
        int g;
        for (int i = 0; i < sq.size(); i++) begin
            g = (toggle && i > 0) ? 1 : 0;
            if (i == gap_at) g = 20;
            send_byte(sq[i], g);
        end
        bv = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!((dn[0] || er[0]) && (dn[1] || er[1]))) begin
            @(posedge clk); #1;
            n++;
            if (n > 300) begin
                tests++; fails++;
                $display("FAIL wait_end timeout: done/error not reached in 300 cycles");
                break;
            end
        end
    endtask

    task automatic chk_basic_log(input int d, input int base, input string tag);
        chk({tag, ".nwrites"}, 64'(wl_a[d].size()), 64'(base + 2));
        if (wl_a[d].size() == base + 2) begin
            chk({tag, ".a0"}, 64'(wl_a[d][base]), 64'd0);
            chk({tag, ".d0"}, 64'(wl_d[d][base]), 64'h00100513);
            chk({tag, ".a1"}, 64'(wl_a[d][base+1]), 64'd1);
            chk({tag, ".d1"}, 64'(wl_d[d][base+1]), 64'h00A505B3);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b0; start = 1'b0; bv = 1'b0; bd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cpu_rst", 64'(cr[0]), 64'd1);
        chk("reset.byte_ready", 64'(rdy[0]), 64'd0);
        chk("reset.done", 64'(dn[0]), 64'd0);
        chk("reset.words_written", 64'(ww0), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic two-word load at full rate
        clear_logs();
        basic_stream();
        pulse_start();
        send_stream(0, -1);
        wait_end();
        chk_basic_log(0, 0, "basic.u0");
        chk_basic_log(1, 0, "basic.u1");
        chk("basic.done", 64'(dn[0]), 64'd1);
        chk("basic.cpu_rst", 64'(cr[0]), 64'd0);
        chk("basic.words", 64'(ww0), 64'd2);

        // Empty image from the DONE state
        clear_logs();
        sq.delete();
        add_hdr(0);
        pulse_start();
        chk("empty.cpu_rst_held", 64'(cr[0]), 64'd1);
        send_stream(0, -1);
        wait_end();
        chk("empty.nwrites", 64'(wl_a[0].size()), 64'd0);
        chk("empty.done", 64'(dn[0]), 64'd1);
        chk("empty.cpu_rst", 64'(cr[0]), 64'd0);
        chk("empty.words", 64'(ww0), 64'd0);

        // Oversize header N=257, then recover
        clear_logs();
        sq.delete();
        add_hdr(257);
        pulse_start();
        send_stream(0, -1);
        wait_end();
        chk("over.error", 64'(er[0]), 64'd1);
        chk("over.cpu_rst", 64'(cr[0]), 64'd1);
        chk("over.byte_ready", 64'(rdy[0]), 64'd0);
        pulse_start();
        chk("over.error_cleared", 64'(er[0]), 64'd0);
        chk("over.ready_again", 64'(rdy[0]), 64'd1);
        basic_stream();
        send_stream(0, -1);
        wait_end();
        chk_basic_log(0, 0, "over.reload");

        // Basic load with toggling valid and a 20-cycle gap mid-word
        clear_logs();
        basic_stream();
        pulse_start();
        send_stream(1, 4);
        wait_end();
        chk_basic_log(0, 0, "stall.u0");
        chk_basic_log(1, 0, "stall.u1");

        // Full depth of the 4-bit instance: N=16
        clear_logs();
        sq.delete();
        add_hdr(16);
        for (int i = 0; i < 16; i++) add_word(32'hA0000000 + 32'(i));
        pulse_start();
        send_stream(0, -1);
        wait_end();
        chk("full.nwrites", 64'(wl_a[1].size()), 64'd16);
        if (wl_a[1].size() == 16)
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("full.a%0d", i), 64'(wl_a[1][i]), 64'(i));
                chk($sformatf("full.d%0d", i), 64'(wl_d[1][i]), 64'(32'hA0000000 + 32'(i)));
            end
        chk("full.words", 64'(ww1), 64'd16);
        chk("full.done", 64'(dn[1]), 64'd1);
        chk("full.addr_wrap", 64'(addr1), 64'd0);
        chk("full.u0_addr", 64'(addr0), 64'd16);

        // N=17: too big for the 4-bit instance only
        clear_logs();
        sq.delete();
        add_hdr(17);
        for (int i = 0; i < 17; i++) add_word(32'h5A000000 + 32'(i));
        pulse_start();
        send_stream(0, -1);
        wait_end();
        chk("n17.u1_error", 64'(er[1]), 64'd1);
        chk("n17.u1_nwrites", 64'(wl_a[1].size()), 64'd0);
        chk("n17.u0_done", 64'(dn[0]), 64'd1);
        chk("n17.u0_words", 64'(ww0), 64'd17);

        // Reset after three bytes of word 1
        clear_logs();
        basic_stream();
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(sq[i], 0);
        bv = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rmid.cpu_rst", 64'(cr[0]), 64'd1);
        chk("rmid.byte_ready", 64'(rdy[0]), 64'd0);
        chk("rmid.mem_we", 64'(we[0]), 64'd0);
        chk("rmid.mem_addr", 64'(addr0), 64'd0);
        chk("rmid.mem_wdata", 64'(wd[0]), 64'd0);
        chk("rmid.words", 64'(ww0), 64'd0);
        chk("rmid.nwrites", 64'(wl_a[0].size()), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send_stream(0, -1);
        wait_end();
        chk_basic_log(0, 1, "rmid.reload");
        chk("rmid.done", 64'(dn[0]), 64'd1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
